nn_layer_top: RTL and testbench

- Single fully-connected neural-net layer engine: 8 neurons, each a dot product of 64 signed Q8.8 inputs with 64 Q8.8 weights.
- Reads weights from the external filter RAM (bvm port) and inputs from the external input RAM (dim port).
- Writes 8 results to the output RAM (dom port).
- Started by a one-cycle go pulse; signals completion with a one-cycle finish pulse.

---
 rtl/nn_layer_pkg.sv | 39 +++
 rtl/nn_mac_unit.sv | 44 ++++
 rtl/nn_layer_top.sv | 144 ++++++++++++++
 tb/tb_nn_layer_top.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nn_layer_pkg.sv
// Shared parameters, controller state encoding and result scaling for the nn_layer engine.
package nn_layer_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned N_IN      = 64;
    localparam int unsigned N_OUT     = 8;
    localparam int unsigned ACC_W     = 40;

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned N_W    = $clog2(N_OUT);
    localparam int unsigned I_W    = $clog2(N_IN);
    localparam int unsigned BVM_AW = N_W + I_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Drop the fraction (floor) and clamp into the signed result range.
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (sh > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (sh < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end else begin
            return sh[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with clear; result_c is the scaled value of the accumulator
// including the product presented this cycle. ReLU applied when NN_LAYER_RELU_EN is defined.
module nn_mac_unit
    import nn_layer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mac_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] act,
    output logic [DATA_W-1:0] result_c
);

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic        [DATA_W-1:0] sat_c;

    always_comb begin
        prod_c = PROD_W'($signed(weight)) * PROD_W'($signed(act));
        sum_c  = acc_q;
        if (mac_en) begin
            sum_c = acc_q + ACC_W'(prod_c);
        end
        acc_d = clr ? '0 : sum_c;
        sat_c = scale_sat(sum_c);
`ifdef NN_LAYER_RELU_EN
        result_c = sat_c[DATA_W-1] ? '0 : sat_c;
`else
        result_c = sat_c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/nn_layer_top.sv
// Fully-connected layer engine: 8 neurons x 64-input Q8.8 dot products, results to output RAM.
// Optional ReLU on results via NN_LAYER_RELU_EN.
module nn_layer_top
    import nn_layer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              xxx__dut__go,
    output logic              dut__xxx__finish,
    output logic [8:0]        dut__bvm__address,
    output logic              dut__bvm__enable,
    output logic              dut__bvm__write,
    output logic [DATA_W-1:0] dut__bvm__data,
    input  logic [DATA_W-1:0] bvm__dut__data,
    output logic [8:0]        dut__dim__address,
    output logic              dut__dim__enable,
    output logic              dut__dim__write,
    output logic [DATA_W-1:0] dut__dim__data,
    input  logic [DATA_W-1:0] dim__dut__data,
    output logic [2:0]        dut__dom__address,
    output logic [DATA_W-1:0] dut__dom__data,
    output logic              dut__dom__enable,
    output logic              dut__dom__write
);

    state_e              state_d, state_q;
    logic [N_W-1:0]      n_d, n_q;
    logic [I_W-1:0]      i_d, i_q;
    logic                rd_en_d, rd_en_q;
    logic [BVM_AW-1:0]   bvm_addr_d, bvm_addr_q;
    logic [BVM_AW-1:0]   dim_addr_d, dim_addr_q;
    logic                dom_en_d, dom_en_q;
    logic [N_W-1:0]      dom_addr_d, dom_addr_q;
    logic [DATA_W-1:0]   dom_data_d, dom_data_q;
    logic                finish_d, finish_q;
    logic                global_enable_d, global_enable_q;
    logic                mac_en_d, mac_en_q;
    logic [DATA_W-1:0]   mac_result_c;

    // Read data lands one cycle after the address cycle; accumulate then.
    nn_mac_unit u_mac (
        .clk      (clk),
        .rst      (reset),
        .mac_en   (mac_en_q & global_enable_q),
        .clr      (state_q == ST_WRITE),
        .weight   (bvm__dut__data),
        .act      (dim__dut__data),
        .result_c (mac_result_c)
    );

    // Next state and counters; registered outputs follow the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        case (state_q)
            ST_IDLE: begin
                if (xxx__dut__go) begin
                    state_d = ST_RUN;
                    n_d     = '0;
                    i_d     = '0;
                end
            end
            ST_RUN: begin
                if (i_q == I_W'(N_IN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_d = i_q + I_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (n_q == N_W'(N_OUT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    n_d     = n_q + N_W'(1);
                    i_d     = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                n_d     = '0;
                i_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        rd_en_d         = (state_d == ST_RUN);
        bvm_addr_d      = rd_en_d ? {n_d, i_d} : '0;
        dim_addr_d      = rd_en_d ? BVM_AW'(i_d) : '0;
        dom_en_d        = (state_d == ST_WRITE);
        dom_addr_d      = dom_en_d ? n_d : '0;
        dom_data_d      = dom_en_d ? mac_result_c : '0;
        finish_d        = (state_d == ST_DONE);
        global_enable_d = (state_d != ST_IDLE);
        mac_en_d        = rd_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            n_q             <= '0;
            i_q             <= '0;
            rd_en_q         <= 1'b0;
            bvm_addr_q      <= '0;
            dim_addr_q      <= '0;
            dom_en_q        <= 1'b0;
            dom_addr_q      <= '0;
            dom_data_q      <= '0;
            finish_q        <= 1'b0;
            global_enable_q <= 1'b0;
            mac_en_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            i_q             <= i_d;
            rd_en_q         <= rd_en_d;
            bvm_addr_q      <= bvm_addr_d;
            dim_addr_q      <= dim_addr_d;
            dom_en_q        <= dom_en_d;
            dom_addr_q      <= dom_addr_d;
            dom_data_q      <= dom_data_d;
            finish_q        <= finish_d;
            global_enable_q <= global_enable_d;
            mac_en_q        <= mac_en_d;
        end
    end

    assign dut__xxx__finish  = finish_q;
    assign dut__bvm__address = bvm_addr_q;
    assign dut__bvm__enable  = rd_en_q;
    assign dut__bvm__write   = 1'b0;
    assign dut__bvm__data    = '0;
    assign dut__dim__address = dim_addr_q;
    assign dut__dim__enable  = rd_en_q;
    assign dut__dim__write   = 1'b0;
    assign dut__dim__data    = '0;
    assign dut__dom__address = dom_addr_q;
    assign dut__dom__data    = dom_data_q;
    assign dut__dom__enable  = dom_en_q;
    assign dut__dom__write   = dom_en_q;

endmodule

// File: tb/tb_nn_layer_top.sv
// Self-checking bench for nn_layer_top: RAM models, dot-product reference model, directed and random runs.
module tb_nn_layer_top;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        finish;
    logic [8:0]  bvm_addr, dim_addr;
    logic        bvm_en, bvm_wr, dim_en, dim_wr;
    logic [15:0] bvm_wdata, dim_wdata, bvm_rd, dim_rd;
    logic [2:0]  dom_addr;
    logic [15:0] dom_data;
    logic        dom_en, dom_wr;

    logic [15:0] wmem [512];
    logic [15:0] xmem [64];

    logic [18:0] wr_q [$];
    int          fin_cnt = 0;
    int          fin_cyc = 0;
    int          acc_cnt = 0;
    int          cyc = 0;
    int          go_cyc = 0;
    int          nerr = 0;
    int          nchk = 0;

    nn_layer_top dut (
        .clk               (clk),
        .reset             (reset),
        .xxx__dut__go      (go),
        .dut__xxx__finish  (finish),
        .dut__bvm__address (bvm_addr),
        .dut__bvm__enable  (bvm_en),
        .dut__bvm__write   (bvm_wr),
        .dut__bvm__data    (bvm_wdata),
        .bvm__dut__data    (bvm_rd),
        .dut__dim__address (dim_addr),
        .dut__dim__enable  (dim_en),
        .dut__dim__write   (dim_wr),
        .dut__dim__data    (dim_wdata),
        .dim__dut__data    (dim_rd),
        .dut__dom__address (dom_addr),
        .dut__dom__data    (dom_data),
        .dut__dom__enable  (dom_en),
        .dut__dom__write   (dom_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bvm_en) bvm_rd <= wmem[bvm_addr];
        if (dim_en) dim_rd <= xmem[dim_addr[5:0]];
    end

    always @(negedge clk) begin
        if (dom_en && dom_wr) wr_q.push_back({dom_addr, dom_data});
        if (finish) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
        if (bvm_en || dim_en) acc_cnt = acc_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        nchk = nchk + 1;
        assert (obs === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact dot product, floor divide by 256, clamp to int16, optional ReLU.
    function automatic logic [15:0] ref_out(input int n);
        longint s;
        logic [15:0] r;
        s = 0;
        for (int i = 0; i < 64; i++) begin
            s = s + longint'($signed(wmem[n*64+i])) * longint'($signed(xmem[i]));
        end
        s = s >>> 8;
        if (s > 32767) r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
        else r = 16'(s);
`ifdef NN_LAYER_RELU_EN
        if (r[15]) r = 16'h0000;
`endif
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 64; i++) begin
                case (mode)
                    0: begin wmem[n*64+i] = 16'h0100; xmem[i] = 16'h0100; end
                    1: begin wmem[n*64+i] = 16'(256 * (n + 1)); xmem[i] = 16'h0080; end
                    2: begin wmem[n*64+i] = 16'hFF00; xmem[i] = 16'h0100; end
                    3: begin wmem[n*64+i] = 16'h7FFF; xmem[i] = 16'h7FFF; end
                    4: begin wmem[n*64+i] = 16'h8000; xmem[i] = 16'h7FFF; end
                    5: begin wmem[n*64+i] = 16'($urandom); xmem[i] = 16'($urandom); end
                    default: begin
                        wmem[n*64+i] = 16'(int'($urandom_range(0, 2047)) - 1024);
                        xmem[i]      = 16'(int'($urandom_range(0, 2047)) - 1024);
                    end
                endcase
            end
        end
    endtask

    task automatic run_and_check(input string tag, input bit go_again);
        int t;
        logic [18:0] w;
        wr_q.delete();
        fin_cnt = 0;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        go_cyc = cyc;
        if (go_again) begin
            repeat (10) @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        t = 0;
        while (fin_cnt == 0 && t < 700) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_finish_cnt"}, fin_cnt, 1);
        check({tag, "_latency"}, fin_cyc - go_cyc, 528);
        check({tag, "_nwrites"}, wr_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wr_q.size()) begin
                w = wr_q[k];
                check($sformatf("%s_addr%0d", tag, k), int'(w[18:16]), k);
                check($sformatf("%s_data%0d", tag, k), int'(w[15:0]), int'(ref_out(k)));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) wmem[i] = '0;
        for (int i = 0; i < 64; i++) xmem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({finish, bvm_en, bvm_wr, dim_en, dim_wr, dom_en, dom_wr, dom_addr}), 0);
        check("reset_addr", int'({bvm_addr, dim_addr}), 0);
        check("reset_data", int'({bvm_wdata, dom_data}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        fill(0); run_and_check("ones", 1'b0);
        fill(1); run_and_check("ramp", 1'b0);
        fill(2); run_and_check("neg", 1'b0);
        fill(3); run_and_check("possat", 1'b0);
        fill(4); run_and_check("negsat", 1'b0);
        fill(6); run_and_check("go_in_run", 1'b1);

        // Reset 100 cycles into a run: everything drops at once, nothing afterwards.
        fill(5);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_outputs", int'({finish, bvm_en, dim_en, dom_en, dom_wr}), 0);
        acc_cnt = 0;
        fin_cnt = 0;
        wr_q.delete();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_accesses", acc_cnt, 0);
        check("abort_finish", fin_cnt, 0);
        check("abort_writes", wr_q.size(), 0);
        run_and_check("after_abort", 1'b0);

        for (int r = 0; r < 2; r++) begin
            fill(5 + r);
            run_and_check($sformatf("rand%0d", r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
